// File: rtl/fsm_test_sequencer.sv
// Test sequencer for a Mealy FSM-under-test: buffers host stimulus, resets the FSM, steps it
// one vector at a time and compacts its outputs into a MISR signature checked against golden.
module fsm_test_sequencer #(
    parameter int unsigned         IN_W     = 5,
    parameter int unsigned         OUT_W    = 8,
    parameter int unsigned         DEPTH    = 16,
    parameter int unsigned         SIG_W    = 16,
    parameter logic [SIG_W-1:0]    SIG_SEED = 16'hFFFF,
    localparam int unsigned        AW       = $clog2(DEPTH),
    localparam int unsigned        CW       = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [IN_W-1:0]  load_data_i,
    input  logic             start_i,
    input  logic [SIG_W-1:0] golden_sig_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [SIG_W-1:0] sig_o,
    output logic [CW-1:0]    n_vec_o,
    output logic             dut_rst_o,
    output logic             dut_en_o,
    output logic [IN_W-1:0]  dut_x_o,
    input  logic [OUT_W-1:0] dut_y_i
);

    typedef enum logic [2:0] {StIdle, StRstDut, StApply, StStep, StDone} state_e;

    state_e            state_q;
    logic [CW-1:0]     n_vec_q;
    logic [CW-1:0]     rd_ptr_q;
    logic [SIG_W-1:0]  sig_q;
    logic [SIG_W-1:0]  sig_d;
    logic              busy_q;
    logic              done_q;
    logic              dut_en_q;
    logic              dut_rst_q;
    logic [IN_W-1:0]   dut_x_q;
    logic [IN_W-1:0]   mem_q [DEPTH];

    logic              host_phase;
    logic              load_fire;
    logic              fb;
    logic [AW-1:0]     nxt_idx;

    assign host_phase   = (state_q == StIdle) || (state_q == StDone);
    assign load_ready_o = host_phase && (n_vec_q < CW'(DEPTH));
    assign load_fire    = load_valid_i && load_ready_o && !clear_i;
    assign nxt_idx      = rd_ptr_q[AW-1:0] + AW'(1);

    // x^16 + x^15 + x^13 + x^4 + 1
    assign fb    = sig_q[SIG_W-1] ^ sig_q[SIG_W-2] ^ sig_q[12] ^ sig_q[3];
    assign sig_d = {sig_q[SIG_W-2:0], fb} ^ SIG_W'(dut_y_i);

    always_ff @(posedge clk_i) begin
        if (load_fire) begin
            mem_q[n_vec_q[AW-1:0]] <= load_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            n_vec_q   <= '0;
            rd_ptr_q  <= '0;
            sig_q     <= SIG_SEED;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dut_en_q  <= 1'b0;
            dut_rst_q <= 1'b0;
            dut_x_q   <= '0;
        end else begin
            dut_en_q  <= 1'b0;
            dut_rst_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (clear_i) begin
                        n_vec_q <= '0;
                        done_q  <= 1'b0;
                    end else begin
                        if (load_fire) begin
                            n_vec_q <= n_vec_q + CW'(1);
                        end
                        if (start_i) begin
                            state_q   <= StRstDut;
                            sig_q     <= SIG_SEED;
                            rd_ptr_q  <= '0;
                            done_q    <= 1'b0;
                            busy_q    <= 1'b1;
                            dut_rst_q <= 1'b1;
                        end
                    end
                end
                StRstDut: begin
                    if (n_vec_q != '0) begin
                        state_q <= StApply;
                        dut_x_q <= mem_q[0];
                    end else begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StApply: begin
                    sig_q    <= sig_d;
                    state_q  <= StStep;
                    dut_en_q <= 1'b1;
                end
                StStep: begin
                    rd_ptr_q <= rd_ptr_q + CW'(1);
                    if (rd_ptr_q == n_vec_q - CW'(1)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dut_x_q <= '0;
                    end else begin
                        state_q <= StApply;
                        dut_x_q <= mem_q[nxt_idx];
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = done_q && (sig_q == golden_sig_i);
    assign sig_o     = sig_q;
    assign n_vec_o   = n_vec_q;
    // The FSM-under-test must see reset for as long as the sequencer itself is in reset.
    assign dut_rst_o = rst_i || dut_rst_q;
    assign dut_en_o  = dut_en_q;
    assign dut_x_o   = dut_x_q;

endmodule
